// File: rtl/musb_bus_interconnect.sv
// Round-robin arbiter of NMASTERS masters onto one bus path, decoded to NSLAVES slaves; unmapped -> bus error.
// Latency: grant registered (slave_enable at k+1), completion = 1 cycle + slave latency, error at k+1.
// Backpressure: masters hold requests until ready/error; optional watchdog via MUSB_BUS_TIMEOUT_EN.
module musb_bus_interconnect #(
   parameter int NMASTERS = 3,
   parameter int NSLAVES = 3,
   parameter logic [NSLAVES*32-1:0] MATCH_ADDR = {32'h1100_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NSLAVES*32-1:0] MATCH_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFE0, 32'hFFFF_0000},
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [32*NMASTERS-1:0]  master_address,
   input  logic [32*NMASTERS-1:0]  master_data_i,
   input  logic [4*NMASTERS-1:0]   master_wr,
   input  logic [NMASTERS-1:0]     master_enable,
   output logic [31:0]             master_data_o,
   output logic [NMASTERS-1:0]     master_ready,
   output logic [NMASTERS-1:0]     master_error,
   input  logic [32*NSLAVES-1:0]   slave_data_i,
   input  logic [NSLAVES-1:0]      slave_ready,
   output logic [31:0]             slave_address,
   output logic [31:0]             slave_data_o,
   output logic [3:0]              slave_wr,
   output logic [NSLAVES-1:0]      slave_enable
);

   localparam int MW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
   localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

   if (NMASTERS < 1 || NMASTERS > 8 || NSLAVES < 1 || NSLAVES > 16 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("musb_bus_interconnect: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   state_t        state;
   logic [MW-1:0] rr_ptr;
   logic [MW-1:0] gnt_idx;
   logic [MW-1:0] req_idx;
   logic [SW-1:0] slv_idx;
   logic [SW-1:0] hit_idx;
   logic          req_vld;
   logic          hit;
   logic          sel_ready;
   logic          timeout_hit;
   logic [31:0]   req_addr;

   // First requester strictly after the last granted master, wrapping.
   always_comb begin : arbiter
      int idx;
      req_vld = 1'b0;
      req_idx = '0;
      idx = 0;
      for (int off = 1; off <= NMASTERS; off++) begin
         idx = (int'(rr_ptr) + off) % NMASTERS;
         if (!req_vld && master_enable[idx]) begin
            req_vld = 1'b1;
            req_idx = MW'(idx);
         end
      end
   end

   assign req_addr = master_address[int'(req_idx)*32 +: 32];

   // Descending scan so the lowest matching slave index wins.
   always_comb begin : decoder
      hit = 1'b0;
      hit_idx = '0;
      for (int i = NSLAVES-1; i >= 0; i--) begin
         if ((req_addr & MATCH_MASK[32*i +: 32]) ==
             (MATCH_ADDR[32*i +: 32] & MATCH_MASK[32*i +: 32])) begin
            hit = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   assign sel_ready = (state == BUSY) && slave_ready[slv_idx];

`ifdef MUSB_BUS_TIMEOUT_EN
   logic [15:0] to_cnt;

   assign timeout_hit = (state == BUSY) && !slave_ready[slv_idx] &&
                        (to_cnt == 16'(TIMEOUT_CYCLES - 1));

   // Held at zero outside BUSY, so every BUSY entry starts from a cleared count.
   always_ff @(posedge clk) begin
      if (rst || state != BUSY)
         to_cnt <= '0;
      else if (!slave_ready[slv_idx])
         to_cnt <= to_cnt + 16'd1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Completion strobes are suppressed while rst is high so an aborted transfer reports nothing.
   always_comb begin : completion
      master_ready = '0;
      master_error = '0;
      master_data_o = '0;
      if (!rst) begin
         if (sel_ready) begin
            master_ready[gnt_idx] = 1'b1;
            master_data_o = slave_data_i[int'(slv_idx)*32 +: 32];
         end
         if (state == ERR || timeout_hit)
            master_error[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= MW'(NMASTERS - 1);
         gnt_idx       <= '0;
         slv_idx       <= '0;
         slave_address <= '0;
         slave_data_o  <= '0;
         slave_wr      <= '0;
         slave_enable  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_vld) begin
                  rr_ptr        <= req_idx;
                  gnt_idx       <= req_idx;
                  slv_idx       <= hit_idx;
                  slave_address <= req_addr;
                  slave_data_o  <= master_data_i[int'(req_idx)*32 +: 32];
                  slave_wr      <= master_wr[int'(req_idx)*4 +: 4];
                  if (hit) begin
                     state        <= BUSY;
                     slave_enable <= NSLAVES'(1) << hit_idx;
                  end else begin
                     state <= ERR;
                  end
               end
            end
            BUSY: begin
               if (sel_ready || timeout_hit) begin
                  state        <= IDLE;
                  slave_enable <= '0;
               end
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_musb_bus_interconnect.sv
// Bench for musb_bus_interconnect: transaction-level model compared every cycle plus directed literal checks.
module tb_musb_bus_interconnect;

   localparam int NM = 3;
   localparam int NS = 3;
   localparam int TO = 8;
   localparam int NEVER = 1000;
   localparam int NSNAP = 1024;
   localparam int NLOG = 64;
   localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h1100_0000};
   localparam logic [31:0] MASK [NS] = '{32'hFFFF_0000, 32'hFFFF_FFE0, 32'hFFFF_FFF8};
   localparam logic [31:0] SDAT [NS] = '{32'hCAFE_F00D, 32'h5111_0001, 32'h5222_0002};

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [32*NM-1:0]  master_address = '0;
   logic [32*NM-1:0]  master_data_i = '0;
   logic [4*NM-1:0]   master_wr = '0;
   logic [NM-1:0]     master_enable = '0;
   logic [31:0]       master_data_o;
   logic [NM-1:0]     master_ready;
   logic [NM-1:0]     master_error;
   logic [32*NS-1:0]  slave_data_i;
   logic [NS-1:0]     slave_ready = '0;
   logic [31:0]       slave_address;
   logic [31:0]       slave_data_o;
   logic [3:0]        slave_wr;
   logic [NS-1:0]     slave_enable;

   assign slave_data_i = {SDAT[2], SDAT[1], SDAT[0]};

   musb_bus_interconnect #(.NMASTERS(NM), .NSLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .master_address(master_address), .master_data_i(master_data_i),
      .master_wr(master_wr), .master_enable(master_enable),
      .master_data_o(master_data_o), .master_ready(master_ready), .master_error(master_error),
      .slave_data_i(slave_data_i), .slave_ready(slave_ready),
      .slave_address(slave_address), .slave_data_o(slave_data_o),
      .slave_wr(slave_wr), .slave_enable(slave_enable)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Slaves: ready after lat[i] extra enabled cycles; a stray slave drives ready while deselected.
   int lat [NS] = '{1, 2, NEVER};
   int en_cyc [NS] = '{0, 0, 0};
   bit stray [NS] = '{0, 0, 0};

   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
         if (slave_enable[i]) begin
            slave_ready[i] = (en_cyc[i] == lat[i]);
            en_cyc[i]++;
         end else begin
            en_cyc[i] = 0;
            slave_ready[i] = stray[i];
         end
      end
   end

   // Masters: current request plus a queue of follow-ups loaded on completion.
   typedef struct {
      int          m;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  w;
   } req_t;
   req_t pend[$];
   logic [NM-1:0] cur_vld = '0;
   logic [31:0]   cur_addr [NM];
   logic [31:0]   cur_dat [NM];
   logic [3:0]    cur_wr [NM];

   task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      req_t r;
      if (!cur_vld[m]) begin
         cur_vld[m] = 1'b1;
         cur_addr[m] = a;
         cur_dat[m] = d;
         cur_wr[m] = w;
      end else begin
         r.m = m; r.a = a; r.d = d; r.w = w;
         pend.push_back(r);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      int r;
      r = -1;
      for (int i = 0; i < NS; i++)
         if (r < 0 && (a & MASK[i]) == (BASE[i] & MASK[i])) r = i;
      return r;
   endfunction

   // Transaction-level model: one outstanding transfer, its age in cycles, and the last granted master.
   bit          m_active = 0;
   int          m_g = 0;
   int          m_s = 0;
   int          m_age = 0;
   int          m_last = NM - 1;
   logic [31:0] m_addr, m_dat;
   logic [3:0]  m_wr;
   logic [NM-1:0] e_rdy, e_err;
   logic [NS-1:0] e_sen;
   logic [31:0]   e_dat;
   bit            done;
   bit            found;
   int            gi;

   logic [31:0]   snap_dat [NSNAP];
   logic [31:0]   snap_sadr [NSNAP];
   logic [31:0]   snap_sdat [NSNAP];
   logic [NM-1:0] snap_rdy [NSNAP];
   logic [NM-1:0] snap_err [NSNAP];
   logic [NS-1:0] snap_sen [NSNAP];
   logic [3:0]    snap_swr [NSNAP];
   int            log_cyc [NLOG];
   int            log_m [NLOG];
   bit            log_err [NLOG];
   int            log_n = 0;

   initial forever begin
      @(negedge clk);
      e_rdy = '0; e_err = '0; e_sen = '0; e_dat = '0; done = 0;
      if (m_active) begin
         if (m_s < 0) begin
            done = 1;
            if (!rst) e_err[m_g] = 1'b1;
         end else begin
            e_sen[m_s] = 1'b1;
            if (slave_ready[m_s]) begin
               done = 1;
               if (!rst) begin
                  e_rdy[m_g] = 1'b1;
                  e_dat = SDAT[m_s];
               end
            end
`ifdef MUSB_BUS_TIMEOUT_EN
            else if (m_age == TO) begin
               done = 1;
               if (!rst) e_err[m_g] = 1'b1;
            end
`endif
         end
      end
      check("master_ready", 32'(master_ready), 32'(e_rdy));
      check("master_error", 32'(master_error), 32'(e_err));
      check("master_data_o", master_data_o, e_dat);
      check("slave_enable", 32'(slave_enable), 32'(e_sen));
      if (m_active && m_s >= 0) begin
         check("slave_address", slave_address, m_addr);
         check("slave_data_o", slave_data_o, m_dat);
         check("slave_wr", 32'(slave_wr), 32'(m_wr));
      end

      if (cyc < NSNAP) begin
         snap_dat[cyc] = master_data_o;   snap_rdy[cyc] = master_ready;
         snap_err[cyc] = master_error;    snap_sen[cyc] = slave_enable;
         snap_sadr[cyc] = slave_address;  snap_sdat[cyc] = slave_data_o;
         snap_swr[cyc] = slave_wr;
      end
      for (int m = 0; m < NM; m++) begin
         if ((master_ready[m] || master_error[m]) && log_n < NLOG) begin
            log_cyc[log_n] = cyc; log_m[log_n] = m; log_err[log_n] = master_error[m];
            log_n++;
         end
      end

      for (int m = 0; m < NM; m++) begin
         if (!rst && (master_ready[m] || master_error[m])) begin
            cur_vld[m] = 1'b0;
            found = 0;
            for (int j = 0; j < pend.size(); j++) begin
               if (!found && pend[j].m == m) begin
                  found = 1;
                  cur_vld[m] = 1'b1;
                  cur_addr[m] = pend[j].a; cur_dat[m] = pend[j].d; cur_wr[m] = pend[j].w;
                  pend.delete(j);
               end
            end
         end
      end
      for (int m = 0; m < NM; m++) begin
         master_enable[m] = cur_vld[m];
         master_address[m*32 +: 32] = cur_addr[m];
         master_data_i[m*32 +: 32] = cur_dat[m];
         master_wr[m*4 +: 4] = cur_wr[m];
      end

      if (rst) begin
         m_active = 0;
         m_last = NM - 1;
      end else if (m_active) begin
         if (done) m_active = 0;
         else m_age++;
      end else begin
         for (int k = 1; k <= NM; k++) begin
            gi = (m_last + k) % NM;
            if (!m_active && master_enable[gi]) begin
               m_active = 1; m_g = gi; m_last = gi; m_age = 1;
               m_addr = master_address[gi*32 +: 32];
               m_dat = master_data_i[gi*32 +: 32];
               m_wr = master_wr[gi*4 +: 4];
               m_s = decode(m_addr);
            end
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc <= c) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((cur_vld != '0 || pend.size() != 0 || m_active) && n < 300) begin
         @(posedge clk);
         #2;
         n++;
      end
      checks++;
      if (n >= 300) begin
         errors++;
         $display("FAIL %s bus still busy after %0d cycles, required idle", name, n);
      end
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int c, c2, l0;
      logic [NM-1:0] acc_err, acc_rdy;
      int order [6] = '{0, 1, 2, 0, 1, 2};

      for (int m = 0; m < NM; m++) begin
         cur_addr[m] = '0; cur_dat[m] = '0; cur_wr[m] = '0;
      end
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      c = cyc;
      wait_until(c);
      check("reset_slave_enable", 32'(snap_sen[c]), 32'h0);
      check("reset_master_ready", 32'(snap_rdy[c]), 32'h0);
      check("reset_slave_address", snap_sadr[c], 32'h0);
      check("reset_data_o", snap_dat[c], 32'h0);

      // All three masters contend from reset: strict 0,1,2 rotation.
      c = cyc; l0 = log_n;
      for (int r = 0; r < 2; r++)
         for (int m = 0; m < NM; m++) issue(m, 32'h0000_0100 * (m + 1), 32'h0, 4'h0);
      wait_idle("rr_contention");
      for (int j = 0; j < 6; j++) check("rr_order", 32'(log_m[l0 + j]), 32'(order[j]));
      check("rr_first_cycle", 32'(log_cyc[l0]), 32'(c + 2));
      check("rr_second_cycle", 32'(log_cyc[l0 + 1]), 32'(c + 5));

      // Master 1 reads memory, one wait state.
      c = cyc;
      issue(1, 32'h0000_0010, 32'h0, 4'h0);
      wait_until(c + 2);
      check("rd_slave_enable", 32'(snap_sen[c + 1]), 32'h1);
      check("rd_no_early_ready", 32'(snap_rdy[c + 1]), 32'h0);
      check("rd_ready", 32'(snap_rdy[c + 2]), 32'h2);
      check("rd_data", snap_dat[c + 2], 32'hCAFE_F00D);
      check("rd_no_error", 32'(snap_err[c + 2]), 32'h0);
      wait_idle("read");

      // Master 0 partial write to GPIO while memory slave drives a stray ready.
      stray[0] = 1;
      c = cyc;
      issue(0, 32'h1000_0004, 32'h1234_5678, 4'b0011);
      wait_until(c + 3);
      check("wr_slave_enable", 32'(snap_sen[c + 1]), 32'h2);
      check("wr_slave_wr", 32'(snap_swr[c + 1]), 32'h3);
      check("wr_addr_hold", snap_sadr[c + 3], 32'h1000_0004);
      check("wr_data_hold", snap_sdat[c + 3], 32'h1234_5678);
      check("wr_no_early_ready", 32'(snap_rdy[c + 2]), 32'h0);
      check("wr_ready", 32'(snap_rdy[c + 3]), 32'h1);
      stray[0] = 0;
      wait_idle("write");

      // Unmapped address from master 2.
      c = cyc;
      issue(2, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF);
      wait_until(c + 2);
      check("unmapped_error", 32'(snap_err[c + 1]), 32'h4);
      check("unmapped_no_enable", 32'(snap_sen[c + 1]), 32'h0);
      check("unmapped_data_zero", snap_dat[c + 1], 32'h0);
      check("unmapped_single_pulse", 32'(snap_err[c + 2]), 32'h0);
      wait_idle("unmapped");

      // UART never answers; master 0 queues a memory read behind it.
      c = cyc;
      issue(2, 32'h1100_0000, 32'h0, 4'h0);
      wait_until(c + 1);
      issue(0, 32'h0000_0040, 32'h0, 4'h0);
`ifdef MUSB_BUS_TIMEOUT_EN
      wait_until(c + 11);
      check("to_no_early_error", 32'(snap_err[c + 7]), 32'h0);
      check("to_error", 32'(snap_err[c + 8]), 32'h4);
      check("to_enable_last", 32'(snap_sen[c + 8]), 32'h4);
      check("to_enable_drop", 32'(snap_sen[c + 9]), 32'h0);
      check("to_next_grant", 32'(snap_rdy[c + 11]), 32'h1);
      wait_idle("timeout");
      c2 = cyc;
      issue(1, 32'h1100_0004, 32'h0, 4'h0);
      wait_until(c2 + 3);
`else
      wait_until(c + 30);
      acc_err = '0; acc_rdy = '0;
      for (int j = c + 1; j <= c + 30; j++) begin
         acc_err |= snap_err[j];
         acc_rdy |= snap_rdy[j];
      end
      check("hang_no_error", 32'(acc_err), 32'h0);
      check("hang_no_ready", 32'(acc_rdy), 32'h0);
      check("hang_still_busy", 32'(snap_sen[c + 30]), 32'h4);
      c2 = c;
`endif

      // Reset during BUSY, then master 0 must win the next contention.
      c = cyc;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      cur_vld = '0;
      pend.delete();
      wait_until(c + 1);
      check("rst_busy_before", 32'(snap_sen[c]), 32'h4);
      check("rst_no_ready", 32'(snap_rdy[c] | snap_err[c]), 32'h0);
      check("rst_enable_drop", 32'(snap_sen[c + 1]), 32'h0);
      check("rst_outputs_zero", 32'(snap_rdy[c + 1] | snap_err[c + 1]), 32'h0);
      check("rst_address_zero", snap_sadr[c + 1], 32'h0);
      c = cyc; l0 = log_n;
      issue(2, 32'h0000_0020, 32'h0, 4'h0);
      issue(0, 32'h0000_0024, 32'h0, 4'h0);
      wait_idle("post_reset");
      check("post_rst_first", 32'(log_m[l0]), 32'h0);
      check("post_rst_first_cycle", 32'(log_cyc[l0]), 32'(c + 2));
      check("post_rst_second", 32'(log_m[l0 + 1]), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/musb_bus_interconnect.md
# musb_bus_interconnect

Parametrised shared-bus interconnect for the MUSB SoC: arbitrates NMASTERS bus masters (core I-port, core D-port, bootloader, DMA, …) onto one transaction path and decodes the address to one of NSLAVES slaves. It replaces the fixed three-master arbiter plus mux-switch pair. It adds round-robin arbitration, bus-error responses for unmapped addresses, and an optional slave-timeout watchdog. It sits between the masters and the memory/GPIO/UART slaves in the SoC top.

## Interface
- NMASTERS, 3: number of masters; 1–8.
- NSLAVES, 3: number of slaves; 1–16.
- MATCH_ADDR, {32'h1100_0000, 32'h1000_0000, 32'h0000_0000}: NSLAVES×32 flattened base addresses; slave i at [32i +: 32].
- MATCH_MASK, {32'hFFFF_FFF8, 32'hFFFF_FFE0, 32'hFFFF_0000}: NSLAVES×32 flattened masks.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; 1–65535; used only with the timeout feature.
- clk  in  1  bus clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- master_address  in  32·NMASTERS  per-master address.
- master_data_i  in  32·NMASTERS  per-master write data.
- master_wr  in  4·NMASTERS  per-master byte write enables; 0 = read.
- master_enable  in  NMASTERS  per-master request.
- master_data_o  out  32  read data, shared by all masters.
- master_ready  out  NMASTERS  per-master completion pulse.
- master_error  out  NMASTERS  per-master error pulse.
- slave_data_i  in  32·NSLAVES  per-slave read data.
- slave_ready  in  NSLAVES  per-slave completion.
- slave_address  out  32  registered address to slaves.
- slave_data_o  out  32  registered write data to slaves.
- slave_wr  out  4  registered byte enables to slaves.
- slave_enable  out  NSLAVES  one-hot slave select.

## Operation
- FSM states: IDLE, BUSY, ERR.
- **IDLE**
  - If any master_enable is high, grant one master by round-robin.
  - Register the granted master's address, data and wr, plus grant index g.
  - Decode slave s = lowest index i with (address & MASK_i) == (ADDR_i & MASK_i).
  - Hit → BUSY. No hit → ERR.
- **Round-robin**
  - Pointer p holds the last granted master.
  - Next grant is the first requester at index p+1, p+2, … wrapping modulo NMASTERS.
  - Reset value of p is NMASTERS−1, so master 0 wins the first contention.
  - p updates only on grant.
- **BUSY**
  - slave_enable[s] = 1.
  - On slave_ready[s]: master_ready[g] = 1 and master_data_o = slave_data_i[s], both combinational in that cycle; next state IDLE.
  - Ready from non-selected slaves is ignored.
- **ERR**
  - One cycle, no slave_enable.
  - master_error[g] = 1, master_data_o = 0.
  - Next state IDLE.
- **Master handshake**
  - The master holds enable, address, data and wr stable until it sees ready or error.
  - If enable is still high in the cycle after completion, it is a new request and competes in arbitration.
  - Deasserting enable mid-transaction does not abort: the transaction completes, and its ready/error pulse is still delivered to g.
- **Outputs outside completion cycles:** master_ready = master_error = 0 and master_data_o = 0.
- **Reset values:** all outputs 0, state IDLE, p = NMASTERS−1, timeout counter 0.
- **Reset mid-transaction:** slave_enable drops in the cycle after rst is sampled, and no ready/error is issued.

## Timing
- Grant is registered: request sampled at edge k → slave_enable high in cycle k+1.
- Completion latency is 1 cycle plus slave latency.
  - A slave returning ready in its first enabled cycle gives ready in cycle k+1.
- Unmapped address: error in cycle k+1.
- Minimum spacing between back-to-back grants is one IDLE cycle.
  - Throughput is at most one transaction per 2 cycles.
- slave_address, slave_data_o and slave_wr are stable throughout BUSY.

## Configuration
- **MUSB_BUS_TIMEOUT_EN defined**
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without the selected slave_ready.
  - When the count reaches TIMEOUT_CYCLES−1 without ready: master_error[g] = 1 in that cycle, slave_enable drops, next state IDLE.
  - If slave_ready arrives in the same cycle the limit is reached, ready wins: no error.
- **MUSB_BUS_TIMEOUT_EN undefined**
  - No counter is built; BUSY waits indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- Master 1 reads 0x0000_0010; memory slave is ready 1 cycle after enable and returns 0xCAFE_F00D.
  - Expect: slave_enable = 3'b001 from k+1, master_ready[1] pulses at k+2 with master_data_o = 0xCAFE_F00D, other ready/error bits 0.
- All three masters hold enable from reset.
  - Expect: grants in order 0, 1, 2, 0, …; no master waits more than 2 transactions.
- Master 0 writes wr = 4'b0011 to 0x1000_0004 with data 0x1234_5678.
  - Expect: slave_enable = 3'b010 and slave_wr = 4'b0011; slave_data_o and slave_address are stable until ready.
- Master 2 accesses 0x2000_0000 (unmapped).
  - Expect: master_error[2] pulses at k+1, slave_enable stays 0, state returns to IDLE.
- With MUSB_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the UART slave never asserts ready.
  - Expect: error on the 8th BUSY cycle, slave_enable drops, the next request is granted.
  - Same stimulus without the macro: no error, the bus stays in BUSY.
- rst asserted during BUSY.
  - Expect: all outputs 0 the next cycle, no ready/error, master 0 wins the next contention.
